// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: shared FSM state, host request bundle and counter-width helper for boot_run_ctrl.
package boot_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CORE_RST, RUN, DONE} ctrl_state_t;
  localparam int HOST_AW = 32;
  localparam int HOST_DW = 32;
  typedef struct packed {
    logic               sel;
    logic               write;
    logic [HOST_AW-1:0] addr;
    logic [HOST_DW-1:0] wdata;
  } host_req_t;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/host_xact_port.sv
// host_xact_port: one access per pselect assertion, one-cycle pready, range check and read-data return.
module host_xact_port
  import boot_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      own,
  input  host_req_t                 req,
  input  logic [DATA_LENGTH-1:0]    mem_rdata,
  output logic                      fire,
  output logic                      acc,
  output logic                      we,
  output logic                      err,
  output logic                      pready,
  output logic [ADDRESS_LENGTH-1:0] addr,
  output logic [DATA_LENGTH-1:0]    wdata,
  output logic [DATA_LENGTH-1:0]    data_out
);
  logic armed, rd_q, oor;
  assign oor      = |req.addr[HOST_AW-1:ADDRESS_LENGTH];
  assign fire     = req.sel & armed;
  assign acc      = fire & ~oor & own;
  assign we       = acc & req.write;
  assign err      = fire & oor;
  assign addr     = acc ? req.addr[ADDRESS_LENGTH-1:0] : '0;
  assign wdata    = acc ? DATA_LENGTH'(req.wdata) : '0;
  assign data_out = rd_q ? mem_rdata : '0;
  // armed comes out of reset low so a held pselect cannot fire before a released cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      pready <= 1'b0;
      rd_q   <= 1'b0;
    end else begin
      armed  <= ~req.sel;
      pready <= fire;
      rd_q   <= acc & ~req.write;
    end
  end
endmodule

// File: rtl/boot_run_ctrl.sv
// boot_run_ctrl: load/reset/run/done sequencer for the multicycle core with host/core memory arbitration.
module boot_run_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 12,
  parameter int RST_CYCLES     = 2,
  parameter int RUN_TIMEOUT    = 40000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instruction_load_start,
  input  logic                      core_select,
  input  logic                      pselect,
  input  logic                      pwrite,
  input  logic [31:0]               addr_in,
  input  logic [31:0]               data_in,
  output logic                      pready,
  output logic [DATA_LENGTH-1:0]    data_out,
  output logic                      core_rst_n,
  input  logic                      core_halt,
  input  logic                      core_mem_en,
  input  logic                      core_mem_write_en,
  input  logic [ADDRESS_LENGTH-1:0] core_mem_addr,
  input  logic [DATA_LENGTH-1:0]    core_mem_data_in,
  output logic [DATA_LENGTH-1:0]    core_mem_data_out,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDRESS_LENGTH-1:0] mem_addr,
  output logic [DATA_LENGTH-1:0]    mem_wdata,
  input  logic [DATA_LENGTH-1:0]    mem_rdata,
  output logic                      run_complete,
  output logic                      timeout,
  output logic                      load_err,
  output logic [ADDRESS_LENGTH:0]   load_count
);
  localparam int RCW = cnt_w(RUN_TIMEOUT);
  localparam int SCW = cnt_w(RST_CYCLES);
  localparam logic [RCW-1:0] RUN_LAST = RCW'((RUN_TIMEOUT > 0) ? RUN_TIMEOUT - 1 : 0);
  localparam logic [SCW-1:0] RST_LAST = SCW'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  ctrl_state_t state;
  logic [RCW-1:0] run_cnt;
  logic [SCW-1:0] rst_cnt;
  host_req_t req;
  logic own, run, timeout_hit, h_fire, h_acc, h_we, h_err;
  logic [ADDRESS_LENGTH-1:0] h_addr;
  logic [DATA_LENGTH-1:0] h_wdata;
  assign req         = '{pselect, pwrite, addr_in, data_in};
  assign own         = state inside {IDLE, LOAD, DONE};
  assign run         = state == RUN;
  assign timeout_hit = (RUN_TIMEOUT != 0) && (run_cnt == RUN_LAST);
  host_xact_port #(.DATA_LENGTH(DATA_LENGTH), .ADDRESS_LENGTH(ADDRESS_LENGTH)) u_port (
    .clk(clk), .rst_n(rst_n), .own(own), .req(req), .mem_rdata(mem_rdata),
    .fire(h_fire), .acc(h_acc), .we(h_we), .err(h_err), .pready(pready),
    .addr(h_addr), .wdata(h_wdata), .data_out(data_out)
  );
  // ownership follows registered state only; host side is already zero when it has no access
  assign mem_en            = run ? core_mem_en : h_acc;
  assign mem_we            = run ? core_mem_write_en : h_we;
  assign mem_addr          = run ? core_mem_addr : h_addr;
  assign mem_wdata         = run ? core_mem_data_in : h_wdata;
  assign core_mem_data_out = mem_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      core_rst_n   <= 1'b0;
      run_complete <= 1'b0;
      timeout      <= 1'b0;
      load_err     <= 1'b0;
      load_count   <= '0;
      run_cnt      <= '0;
      rst_cnt      <= '0;
    end else begin
      if (h_err) load_err <= 1'b1;
      if (state == LOAD && h_we && ~&load_count) load_count <= load_count + 1'b1;
      case (state)
        IDLE:
          if (instruction_load_start) begin
            state      <= LOAD;
            load_count <= '0;
            load_err   <= h_err;
          end else if (core_select) begin
            state        <= CORE_RST;
            rst_cnt      <= '0;
            run_complete <= 1'b0;
            timeout      <= 1'b0;
          end
        LOAD: if (!instruction_load_start && !h_fire) state <= IDLE;
        CORE_RST:
          if (rst_cnt == RST_LAST) begin
            state      <= RUN;
            run_cnt    <= '0;
            core_rst_n <= 1'b1;
          end else rst_cnt <= rst_cnt + 1'b1;
        RUN:
          if (!core_select) begin
            state      <= IDLE;
            core_rst_n <= 1'b0;
          end else if (core_halt || timeout_hit) begin
            state        <= DONE;
            core_rst_n   <= 1'b0;
            run_complete <= 1'b1;
            timeout      <= ~core_halt;
          end else run_cnt <= run_cnt + 1'b1;
        DONE:
          if (!core_select) begin
            state        <= IDLE;
            run_complete <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/boot_run_ctrl.md
Name: boot_run_ctrl

Overview:
- Sequences the multicycle RISC-V core through load, reset, run and done phases.
- Arbitrates the single shared instruction/data memory between the external host port (APB-style pselect/pwrite) and the core's memory port.
- Sits inside riscv_multi_top between the host interface, the core and the memory macro.
- Generates the core reset and the run_complete flag.

Parameters:
- DATA_LENGTH, 32, memory word width.
- ADDRESS_LENGTH, 12, memory word-address width.
- RST_CYCLES, 2, cycles core_rst_n is held low before RUN.
- RUN_TIMEOUT, 40000, cycles in RUN before forced DONE (0 disables the timeout).

Ports:
- clk in 1: system clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- instruction_load_start in 1: host requests the load phase.
- core_select in 1: host requests a core run.
- pselect in 1: host transaction select.
- pwrite in 1: host write (1) / read (0).
- addr_in in 32: host word address.
- data_in in 32: host write data.
- pready out 1: one-cycle transaction-complete pulse.
- data_out out DATA_LENGTH: host read data, valid while pready=1.
- core_rst_n out 1: active-low core reset.
- core_halt in 1: core reached halt (ecall/end-of-program).
- core_mem_en in 1: core memory request.
- core_mem_write_en in 1: core memory write.
- core_mem_addr in ADDRESS_LENGTH: core memory address.
- core_mem_data_in in DATA_LENGTH: core write data.
- core_mem_data_out out DATA_LENGTH: core read data.
- mem_en out 1: memory enable.
- mem_we out 1: memory write enable.
- mem_addr out ADDRESS_LENGTH: memory address.
- mem_wdata out DATA_LENGTH: memory write data.
- mem_rdata in DATA_LENGTH: memory read data, 1-cycle synchronous latency.
- run_complete out 1: run finished, level.
- timeout out 1: DONE was reached via timeout, level.
- load_err out 1: sticky flag, out-of-range host address seen.
- load_count out ADDRESS_LENGTH+1: words written in the current load phase.

Behaviour:
- Reset (rst_n=0, async):
  - State is IDLE.
  - core_rst_n=0.
  - pready, run_complete, timeout, load_err, load_count, data_out and all mem_* outputs are 0.
- States: IDLE, LOAD, CORE_RST, RUN, DONE. One-hot or binary encoding is free.
- IDLE:
  - Host owns memory; core_rst_n=0.
  - instruction_load_start=1 moves to LOAD and clears load_count and load_err.
  - Otherwise core_select=1 moves to CORE_RST.
  - If both are high, load wins.
- Host transaction (valid in IDLE, LOAD and DONE):
  - Cycle T: pselect=1 with the port armed starts a transaction. mem_en=1, mem_we=pwrite, mem_addr=addr_in[ADDRESS_LENGTH-1:0], mem_wdata=data_in. The port disarms.
  - Cycle T+1: pready=1 for exactly one cycle; on reads, data_out=mem_rdata.
  - The port re-arms only after a cycle with pselect=0. Holding pselect for N cycles therefore yields exactly one access.
- Out-of-range addresses: addr_in[31:ADDRESS_LENGTH]≠0 suppresses mem_en, still pulses pready, returns data_out=0 and sets load_err.
- Writes in LOAD increment load_count (saturating at its maximum).
- Writes in IDLE/DONE are allowed but not counted.
- LOAD exits to IDLE when instruction_load_start=0 and no transaction is in flight. An in-flight pready still completes first.
- CORE_RST:
  - core_rst_n=0 for RST_CYCLES cycles, counted from entry; then go to RUN.
  - run_complete and timeout are cleared on entry.
- RUN:
  - core_rst_n=1; the core owns memory.
  - mem_en=core_mem_en, mem_we=core_mem_write_en, mem_addr=core_mem_addr, mem_wdata=core_mem_data_in, all combinational.
  - core_mem_data_out=mem_rdata at all times.
  - Host transactions complete (pready pulse, data_out=0) with no memory access.
  - The run counter increments each cycle.
  - core_halt=1 goes to DONE.
  - Counter reaching RUN_TIMEOUT-1 (when RUN_TIMEOUT≠0) goes to DONE and sets timeout=1.
  - If core_halt and the timeout coincide, halt wins and timeout stays 0.
  - core_select=0 in RUN aborts to IDLE with core_rst_n=0 and run_complete=0.
- DONE:
  - run_complete=1 (registered, first high the cycle after the DONE transition).
  - core_rst_n=0; host owns memory for result readback.
  - core_select=0 returns to IDLE and clears run_complete.
  - instruction_load_start=1 in DONE is ignored until IDLE is reached.
- Memory ownership mux is combinational from registered state. No mem_en glitch across state changes: a host access issued in the cycle before RUN completes its pready.

Decomposition:
- Package boot_ctrl_pkg:
  - state enum ctrl_state_t {IDLE, LOAD, CORE_RST, RUN, DONE}.
  - localparams for counter widths (run counter $clog2(RUN_TIMEOUT+1)).
  - Typedef host_req_t bundling sel/write/addr/wdata.
- One sub-module, host_xact_port: arm/disarm logic, one-cycle pready pulse, address range check and read-data capture.
- The top holds the FSM, counters and ownership mux.

Test Plan:
- Reset: assert rst_n=0 mid-RUN → all outputs 0 immediately, state IDLE, core_rst_n=0.
- Load: instruction_load_start=1; write addr 0..3 with data 0xA0..0xA3, pselect held 4 cycles each → exactly 4 mem writes, 4 pready pulses, load_count=4. Then read addr 2 in IDLE → data_out=0xA2 on pready.
- Range error: write addr 0x1000 in LOAD → no mem_en, pready pulses, load_err=1, load_count unchanged.
- Run: core_select=1 → core_rst_n low exactly 2 cycles, then high. Core writes 0x55 at addr 0x10 appear on mem_*. A host write during RUN has no mem effect. core_halt=1 → run_complete=1 next cycle, timeout=0.
- Timeout: RUN_TIMEOUT=16, core_halt never asserted → DONE after 16 RUN cycles with timeout=1. core_select=0 → IDLE, run_complete=0.
- Abort/priority: core_select and instruction_load_start both high in IDLE → LOAD. core_select dropped in RUN → IDLE, core_rst_n=0, run_complete stays 0.
